multicycle_control: RTL
=======================

// Module: multicycle_control
// PURPOSE
//  Parametrised multi-cycle control unit for the datapath/control processor split.
//  Sequences each instruction through IF/DEC/EXE/MEM/WB states; only the active stage's datapath strobes fire.
//  Adds a memory req/ack handshake with timeout, an instruction-register load strobe, branch resolution and an illegal-opcode halt.
// PARAMETERS
//  OPC_W      6    opcode width, Instr[31:32-OPC_W]
//  FUNC_W     4    ALU function width; R-type func = Instr[FUNC_W-1:0]
//  TIMEOUT    16   max cycles waiting for Mem_Ack before HALT (>=1)
//  CNT_W      5    timeout counter width; 2**CNT_W > TIMEOUT
// PORTS
//  Clk            in   1       clock, rising edge
//  Reset          in   1       synchronous, active-high
//  Instr          in   32      IR contents from datapath
//  ALU_zero       in   1       zero flag of RF_A-RF_B compare
//  Mem_Ack        in   1       memory done, 1-cycle pulse
//  IR_LdEn        out  1       load instruction register
//  PC_sel         out  1       0: PC+4, 1: PC+4+(imm<<2)
//  PC_LdEn        out  1       PC write strobe
//  RF_B_sel       out  1       0: rt=Instr[15:11], 1: rd=Instr[20:16]
//  RF_WrEn        out  1       register file write strobe
//  RF_WrData_sel  out  1       0: ALU result, 1: MEM_out
//  ALU_Bin_sel    out  1       0: RF_B, 1: immediate
//  ALU_func       out  FUNC_W  ALU operation
//  MEM_WrEn       out  1       data memory write strobe
//  Mem_Req        out  1       memory access request
//  Halted         out  1       sticky: illegal opcode or timeout
//  State          out  4       current state code (debug)
// BEHAVIOUR
//  Encodings: R-type 100000; li 111000; addi 110000; andi 110010; ori 110011; b 111111;
//   beq 000000; bne 000001; lw 001111; sw 011111; anything else illegal.
//  States (code): IF=1, IF_W=2, DEC=3, EXE=4, MEM=5, MEM_W=6, WB=7, HALT=8; reset holds 0.
//  Reset high at an edge: State=0, all outputs 0, counter 0, Halted cleared; next edge with Reset low -> IF.
//   Reset mid-instruction aborts it; no strobe issued in the cycle after Reset sampled.
//  IF: Mem_Req=1 -> IF_W. IF_W: Mem_Req=1; on Mem_Ack: IR_LdEn=1, PC_LdEn=1 (PC_sel=0) -> DEC.
//  DEC: decode Instr; illegal -> HALT; else -> EXE. No strobes.
//  EXE: ALU_func = func (R-type), 0000 add (addi/lw/sw/li), 0010 and, 0011 or, 0001 sub (beq/bne).
//   ALU_Bin_sel=1 for immediate forms and lw/sw. li uses RF_A=r0 semantics via add.
//   b: PC_sel=1, PC_LdEn=1 -> IF. beq/bne: PC_sel=PC_LdEn=(ALU_zero==beq) -> IF.
//   lw/sw -> MEM; ALU forms -> WB.
//  MEM: Mem_Req=1, MEM_WrEn=1 only for sw -> MEM_W. MEM_W: hold Mem_Req (and MEM_WrEn for sw);
//   on Mem_Ack: sw -> IF, lw -> WB. MEM_WrEn is never high without Mem_Req.
//  WB: RF_WrEn=1 for exactly one cycle; RF_WrData_sel=1 for lw; -> IF.
//  RF_B_sel=1 for sw/beq/bne (store data / compare operand), else 0; held stable DEC..WB.
//  Timeout: counter clears on entry to IF_W/MEM_W, increments each wait cycle without Ack;
//   reaching TIMEOUT -> HALT. Ack in the same cycle the count hits TIMEOUT wins (no halt).
//  Mem_Ack outside IF_W/MEM_W is ignored. Ack in IF/MEM (before wait state) is ignored too.
//  HALT: all strobes 0, Mem_Req=0, Halted=1; exits only via Reset.
//  Outputs are Moore-decoded from registered State and Instr; no combinational path Mem_Ack->strobes except
//   IR_LdEn/PC_LdEn in IF_W, and the sw/lw exit from MEM_W (single-level decode).
//  Latency (ack on first wait cycle): ALU op 6 cycles, lw 8, sw 7, branch 5.
// TESTING
//  Reset 3 cycles then release, Ack every first wait cycle -> State 0,1,2,3..., all strobes 0 during reset.
//  R-type add func=0000, Ack immediate -> IR_LdEn@IF_W, ALU_func=0000, ALU_Bin_sel=0, RF_WrEn 1 cycle in WB, 6-cycle period.
//  lw with Ack delayed 3 cycles in MEM_W -> Mem_Req high 5 cycles, MEM_WrEn=0, RF_WrData_sel=1 in WB.
//  beq ALU_zero=1 -> PC_sel=PC_LdEn=1 in EXE; bne ALU_zero=1 -> PC_LdEn=0.
//  TIMEOUT=4, no Ack in IF_W -> HALT after 4 wait cycles, Halted=1 sticky until Reset; opcode 101010 -> HALT after DEC.
//  Reset asserted in MEM_W of sw -> MEM_WrEn/Mem_Req drop at next edge, restart at IF.

Source files
------------

// File: rtl/multicycle_control_if.sv
// Control/datapath bus for the multi-cycle control unit.
// The master side is the control unit, which drives the strobes.
// The slave side is the datapath, which supplies the IR, the zero flag and the memory ack.
interface multicycle_control_if #(
    parameter int FUNC_W = 4
);
    logic [31:0]       Instr;
    logic              ALU_zero;
    logic              Mem_Ack;
    logic              IR_LdEn;
    logic              PC_sel;
    logic              PC_LdEn;
    logic              RF_B_sel;
    logic              RF_WrEn;
    logic              RF_WrData_sel;
    logic              ALU_Bin_sel;
    logic [FUNC_W-1:0] ALU_func;
    logic              MEM_WrEn;
    logic              Mem_Req;
    logic              Halted;
    logic [3:0]        State;

    modport master (
        input  Instr, ALU_zero, Mem_Ack,
        output IR_LdEn, PC_sel, PC_LdEn, RF_B_sel, RF_WrEn, RF_WrData_sel,
               ALU_Bin_sel, ALU_func, MEM_WrEn, Mem_Req, Halted, State
    );

    modport slave (
        output Instr, ALU_zero, Mem_Ack,
        input  IR_LdEn, PC_sel, PC_LdEn, RF_B_sel, RF_WrEn, RF_WrData_sel,
               ALU_Bin_sel, ALU_func, MEM_WrEn, Mem_Req, Halted, State
    );
endinterface

// File: rtl/multicycle_control.sv
// Multi-cycle control unit.
// It steps every instruction through IF/DEC/EXE/MEM/WB, with memory wait states
// guarded by a timeout. Outputs are decoded from the registered state and the IR.
// Mem_Ack reaches the strobes combinationally only for the fetch strobes in IF_W.
// It also reaches the next state on leaving a wait state.
module multicycle_control #(
    parameter int OPC_W   = 6,
    parameter int FUNC_W  = 4,
    parameter int TIMEOUT = 16,
    parameter int CNT_W   = 5
) (
    input  logic               Clk,
    input  logic               Reset,
    multicycle_control_if.master bus
);

    typedef enum logic [3:0] {
        S_RST  = 4'd0,
        S_IF   = 4'd1,
        S_IF_W = 4'd2,
        S_DEC  = 4'd3,
        S_EXE  = 4'd4,
        S_MEM  = 4'd5,
        S_MEM_W = 4'd6,
        S_WB   = 4'd7,
        S_HALT = 4'd8
    } state_t;

    localparam logic [OPC_W-1:0] OP_R    = OPC_W'(6'b100000);
    localparam logic [OPC_W-1:0] OP_LI   = OPC_W'(6'b111000);
    localparam logic [OPC_W-1:0] OP_ADDI = OPC_W'(6'b110000);
    localparam logic [OPC_W-1:0] OP_ANDI = OPC_W'(6'b110010);
    localparam logic [OPC_W-1:0] OP_ORI  = OPC_W'(6'b110011);
    localparam logic [OPC_W-1:0] OP_B    = OPC_W'(6'b111111);
    localparam logic [OPC_W-1:0] OP_BEQ  = OPC_W'(6'b000000);
    localparam logic [OPC_W-1:0] OP_BNE  = OPC_W'(6'b000001);
    localparam logic [OPC_W-1:0] OP_LW   = OPC_W'(6'b001111);
    localparam logic [OPC_W-1:0] OP_SW   = OPC_W'(6'b011111);

    state_t             state_q, state_d;
    logic [CNT_W-1:0]   cnt_q, cnt_d;
    logic [CNT_W-1:0]   cnt_inc;
    logic               timeout_hit;

    logic [OPC_W-1:0]   opcode;
    logic               is_r, is_li, is_addi, is_andi, is_ori;
    logic               is_b, is_beq, is_bne, is_lw, is_sw;
    logic               is_imm, is_legal, uses_rf_b, br_taken;

    logic               ir_ld, pc_sel, pc_ld, rf_b_sel, rf_wr, rf_wd_sel;
    logic               alu_bin_sel, mem_wr, mem_req, halted;
    logic [FUNC_W-1:0]  alu_func;

    // Bits between the opcode and the R-type func belong to the datapath only.
    logic               unused_instr_bits;
    assign unused_instr_bits = ^bus.Instr[31-OPC_W:FUNC_W];

    // Instruction class decode from the IR opcode field.
    always_comb begin
        opcode    = bus.Instr[31:32-OPC_W];
        is_r      = (opcode == OP_R);
        is_li     = (opcode == OP_LI);
        is_addi   = (opcode == OP_ADDI);
        is_andi   = (opcode == OP_ANDI);
        is_ori    = (opcode == OP_ORI);
        is_b      = (opcode == OP_B);
        is_beq    = (opcode == OP_BEQ);
        is_bne    = (opcode == OP_BNE);
        is_lw     = (opcode == OP_LW);
        is_sw     = (opcode == OP_SW);
        is_imm    = is_li | is_addi | is_andi | is_ori | is_lw | is_sw;
        is_legal  = is_r | is_imm | is_b | is_beq | is_bne;
        uses_rf_b = is_sw | is_beq | is_bne;
        // beq branches on zero, bne on non-zero.
        br_taken  = (bus.ALU_zero == is_beq);
    end

    // Wait-state counter: the next value, and whether that value reaches the limit.
    assign cnt_inc     = cnt_q + CNT_W'(1);
    assign timeout_hit = (cnt_inc == CNT_W'(TIMEOUT));

    // Next state and output decode. Every output defaults to 0, so only the active stage strobes.
    always_comb begin
        state_d     = state_q;
        cnt_d       = '0;
        ir_ld       = 1'b0;
        pc_sel      = 1'b0;
        pc_ld       = 1'b0;
        rf_b_sel    = 1'b0;
        rf_wr       = 1'b0;
        rf_wd_sel   = 1'b0;
        alu_bin_sel = 1'b0;
        alu_func    = '0;
        mem_wr      = 1'b0;
        mem_req     = 1'b0;
        halted      = 1'b0;

        case (state_q)
            S_RST: begin
                state_d = S_IF;
            end
            S_IF: begin
                // An ack before the wait state belongs to no request of ours.
                mem_req = 1'b1;
                state_d = S_IF_W;
            end
            S_IF_W: begin
                mem_req = 1'b1;
                if (bus.Mem_Ack) begin
                    ir_ld   = 1'b1;
                    pc_ld   = 1'b1;
                    state_d = S_DEC;
                end else begin
                    cnt_d = cnt_inc;
                    if (timeout_hit) begin
                        state_d = S_HALT;
                    end
                end
            end
            S_DEC: begin
                rf_b_sel = uses_rf_b;
                state_d  = is_legal ? S_EXE : S_HALT;
            end
            S_EXE: begin
                rf_b_sel    = uses_rf_b;
                alu_bin_sel = is_imm;
                if (is_r) begin
                    alu_func = bus.Instr[FUNC_W-1:0];
                end else if (is_andi) begin
                    alu_func = FUNC_W'(4'b0010);
                end else if (is_ori) begin
                    alu_func = FUNC_W'(4'b0011);
                end else if (is_beq || is_bne) begin
                    alu_func = FUNC_W'(4'b0001);
                end
                if (is_b) begin
                    pc_sel  = 1'b1;
                    pc_ld   = 1'b1;
                    state_d = S_IF;
                end else if (is_beq || is_bne) begin
                    pc_sel  = br_taken;
                    pc_ld   = br_taken;
                    state_d = S_IF;
                end else if (is_lw || is_sw) begin
                    state_d = S_MEM;
                end else begin
                    state_d = S_WB;
                end
            end
            S_MEM: begin
                rf_b_sel = uses_rf_b;
                mem_req  = 1'b1;
                mem_wr   = is_sw;
                state_d  = S_MEM_W;
            end
            S_MEM_W: begin
                rf_b_sel = uses_rf_b;
                mem_req  = 1'b1;
                mem_wr   = is_sw;
                if (bus.Mem_Ack) begin
                    state_d = is_sw ? S_IF : S_WB;
                end else begin
                    cnt_d = cnt_inc;
                    if (timeout_hit) begin
                        state_d = S_HALT;
                    end
                end
            end
            S_WB: begin
                rf_b_sel  = uses_rf_b;
                rf_wr     = 1'b1;
                rf_wd_sel = is_lw;
                state_d   = S_IF;
            end
            S_HALT: begin
                halted  = 1'b1;
                state_d = S_HALT;
            end
            default: begin
                state_d = S_HALT;
            end
        endcase
    end

    // State and wait-counter registers with synchronous reset.
    always_ff @(posedge Clk) begin
        if (Reset) begin
            state_q <= S_RST;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
        end
    end

    assign bus.IR_LdEn       = ir_ld;
    assign bus.PC_sel        = pc_sel;
    assign bus.PC_LdEn       = pc_ld;
    assign bus.RF_B_sel      = rf_b_sel;
    assign bus.RF_WrEn       = rf_wr;
    assign bus.RF_WrData_sel = rf_wd_sel;
    assign bus.ALU_Bin_sel   = alu_bin_sel;
    assign bus.ALU_func      = alu_func;
    assign bus.MEM_WrEn      = mem_wr;
    assign bus.Mem_Req       = mem_req;
    assign bus.Halted        = halted;
    assign bus.State         = state_q;

endmodule
